// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR responder with trap state, 64-bit counters and
//            interrupt-pending output for the rv32imac core.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_i,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic        csr_wen_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_ack_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic [63:0] mtime_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_o,
    output logic        irq_o
);

    localparam logic [11:0] c_MSTATUS    = 12'h300;
    localparam logic [11:0] c_MISA       = 12'h301;
    localparam logic [11:0] c_MEDELEG    = 12'h302;
    localparam logic [11:0] c_MIDELEG    = 12'h303;
    localparam logic [11:0] c_MIE        = 12'h304;
    localparam logic [11:0] c_MTVEC      = 12'h305;
    localparam logic [11:0] c_MCOUNTEREN = 12'h306;
    localparam logic [11:0] c_MSCRATCH   = 12'h340;
    localparam logic [11:0] c_MEPC       = 12'h341;
    localparam logic [11:0] c_MCAUSE     = 12'h342;
    localparam logic [11:0] c_MTVAL      = 12'h343;
    localparam logic [11:0] c_MIP        = 12'h344;
    localparam logic [11:0] c_MCYCLE     = 12'hB00;
    localparam logic [11:0] c_MINSTRET   = 12'hB02;
    localparam logic [11:0] c_MCYCLEH    = 12'hB80;
    localparam logic [11:0] c_MINSTRETH  = 12'hB82;
    localparam logic [11:0] c_CYCLE      = 12'hC00;
    localparam logic [11:0] c_TIME       = 12'hC01;
    localparam logic [11:0] c_INSTRET    = 12'hC02;
    localparam logic [11:0] c_CYCLEH     = 12'hC80;
    localparam logic [11:0] c_TIMEH      = 12'hC81;
    localparam logic [11:0] c_INSTRETH   = 12'hC82;
    localparam logic [11:0] c_MVENDORID  = 12'hF11;
    localparam logic [11:0] c_MARCHID    = 12'hF12;
    localparam logic [11:0] c_MIMPID     = 12'hF13;
    localparam logic [11:0] c_MHARTID    = 12'hF14;
    localparam logic [31:0] c_MISA_VAL   = 32'h4000_1105;
    localparam logic [31:0] c_MIE_MASK   = 32'h0000_0888;

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_illegal;
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_mip;
    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic        w_known;
    logic        w_illegal;
    logic        w_accept;
    logic        w_wr;
    logic [31:0] w_wval;

    assign w_mip     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    always_comb begin
        w_known = 1'b1;
        w_old   = '0;
        case (csr_addr_i)
            c_MSTATUS:                         w_old = w_mstatus;
            c_MISA:                            w_old = c_MISA_VAL;
            c_MEDELEG, c_MIDELEG, c_MCOUNTEREN: w_old = '0;
            c_MIE:                             w_old = r_mie;
            c_MTVEC:                           w_old = r_mtvec;
            c_MSCRATCH:                        w_old = r_mscratch;
            c_MEPC:                            w_old = r_mepc;
            c_MCAUSE:                          w_old = r_mcause;
            c_MTVAL:                           w_old = r_mtval;
            c_MIP:                             w_old = w_mip;
            c_MCYCLE, c_CYCLE:                 w_old = r_mcycle[31:0];
            c_MCYCLEH, c_CYCLEH:               w_old = r_mcycle[63:32];
            c_MINSTRET, c_INSTRET:             w_old = r_minstret[31:0];
            c_MINSTRETH, c_INSTRETH:           w_old = r_minstret[63:32];
            c_TIME:                            w_old = mtime_i[31:0];
            c_TIMEH:                           w_old = mtime_i[63:32];
            c_MVENDORID, c_MARCHID, c_MIMPID:  w_old = '0;
            c_MHARTID:                         w_old = HART_ID;
            default:                           w_known = 1'b0;
        endcase
    end

    // Trap and mret squash a coincident request entirely, including its ack.
    assign w_accept  = csr_req_i && (csr_op_i != 2'b00) && !trap_i && !mret_i;
    assign w_illegal = !w_known || (csr_wen_i && (csr_addr_i[11:10] == 2'b11));
    assign w_wr      = w_accept && csr_wen_i && !w_illegal;

    always_comb begin
        case (csr_op_i)
            2'b01:   w_wval = csr_wdata_i;
            2'b10:   w_wval = w_old | csr_wdata_i;
            2'b11:   w_wval = w_old & ~csr_wdata_i;
            default: w_wval = w_old;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack          <= 1'b0;
            r_rdata        <= '0;
            r_illegal      <= 1'b0;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST & ~32'h3;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else begin
            r_ack     <= w_accept;
            r_illegal <= w_accept && w_illegal;
            r_rdata   <= (w_accept && !w_illegal) ? w_old : '0;
            if (trap_i) begin
                r_mepc         <= trap_pc_i & ~32'h1;
                r_mcause       <= trap_cause_i;
                r_mtval        <= trap_tval_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr) begin
                case (csr_addr_i)
                    c_MSTATUS: begin
                        r_mstatus_mie  <= w_wval[3];
                        r_mstatus_mpie <= w_wval[7];
                    end
                    c_MIE:      r_mie      <= w_wval & c_MIE_MASK;
                    c_MTVEC:    r_mtvec    <= w_wval & ~32'h3;
                    c_MSCRATCH: r_mscratch <= w_wval;
                    c_MEPC:     r_mepc     <= w_wval & ~32'h1;
                    c_MCAUSE:   r_mcause   <= w_wval;
                    c_MTVAL:    r_mtval    <= w_wval;
                    default:    ;
                endcase
            end
        end
    end

    // A write to one half of a counter freezes the other half for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr && csr_addr_i == c_MCYCLE)
                r_mcycle[31:0] <= w_wval;
            else if (w_wr && csr_addr_i == c_MCYCLEH)
                r_mcycle[63:32] <= w_wval;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && csr_addr_i == c_MINSTRET)
                r_minstret[31:0] <= w_wval;
            else if (w_wr && csr_addr_i == c_MINSTRETH)
                r_minstret[63:32] <= w_wval;
            else if (instret_i)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    assign csr_ack_o     = r_ack;
    assign csr_rdata_o   = r_rdata;
    assign csr_illegal_o = r_illegal;
    assign trap_vector_o = {r_mtvec[31:2], 2'b00};
    assign mepc_o        = r_mepc;
    assign irq_o         = r_mstatus_mie && (|(w_mip & r_mie));

endmodule
`default_nettype wire
